// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen -- serial bit-sequence generator
//
// Captures a pattern word on a start request and shifts it out MSB-first
// (bit [len_m1] first, bit 0 last), one bit per clock, for repeat_n+1 passes.
// A one-cycle done pulse follows the final bit, then the block returns to
// IDLE and accepts the next request.
//
// Optional feature: define SEQ_GAP_EN to insert one GAP cycle (seq_valid=0)
// between consecutive passes. Undefined, passes run back-to-back.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   start      request pulse, sampled only in IDLE
//   pattern    bits to send (captured at start)
//   len_m1     sequence length minus 1 (clamped to MAX_LEN-1 at capture)
//   repeat_n   extra passes (total passes = repeat_n+1)
//   seq_out    registered serial data, 0 whenever seq_valid=0
//   seq_valid  seq_out carries a pattern bit this cycle
//   busy       high in SHIFT, GAP and DONE
//   done       one-cycle pulse after the final bit
//   state_out  current state code (IDLE=0, SHIFT=1, GAP=2, DONE=3)
// ---------------------------------------------------------------------------
module seq_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 4,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len_m1,
    input  logic [REP_W-1:0]   repeat_n,
    output logic               seq_out,
    output logic               seq_valid,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state_out
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SHIFT = 4'd1,
        GAP   = 4'd2,
        DONE  = 4'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN - 1);

    state_t             state;
    logic [MAX_LEN-1:0] pat;      // captured pattern
    logic [LEN_W-1:0]   len;      // captured (clamped) length minus 1
    logic [LEN_W-1:0]   idx;      // index of the bit currently on seq_out
    logic [REP_W-1:0]   rep_cnt;  // passes still to run after this one
    logic [LEN_W-1:0]   len_cap;

    // Lengths beyond the pattern register are clamped so idx always
    // addresses a real pattern bit.
    always_comb begin
        len_cap = (32'(len_m1) > MAX_LEN - 1) ? LEN_MAX : len_m1;
    end

    assign state_out = state;

    // NOTE: every register here, datapath included, is cleared by reset so a
    // truncated stream leaves no stale pattern behind; all state updates use
    // non-blocking assignments so each branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pat       <= '0;
            len       <= '0;
            idx       <= '0;
            rep_cnt   <= '0;
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    seq_out   <= 1'b0;
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        pat       <= pattern;
                        len       <= len_cap;
                        idx       <= len_cap;
                        rep_cnt   <= repeat_n;
                        state     <= SHIFT;
                        // First bit is presented in the cycle right after capture.
                        seq_out   <= pattern[len_cap];
                        seq_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (idx != '0) begin
                        idx     <= idx - LEN_W'(1);
                        seq_out <= pat[idx - LEN_W'(1)];
                    end else if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - REP_W'(1);
                        idx     <= len;
`ifdef SEQ_GAP_EN
                        state     <= GAP;
                        seq_out   <= 1'b0;
                        seq_valid <= 1'b0;
`else
                        // Next pass starts immediately, no idle bit between.
                        seq_out <= pat[len];
`endif
                    end else begin
                        state     <= DONE;
                        seq_out   <= 1'b0;
                        seq_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end

`ifdef SEQ_GAP_EN
                GAP: begin
                    state     <= SHIFT;
                    seq_out   <= pat[idx];
                    seq_valid <= 1'b1;
                end
`endif

                DONE: begin
                    // start is deliberately ignored here.
                    state     <= IDLE;
                    seq_out   <= 1'b0;
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end

                default: begin
                    // Unused codes recover to IDLE on the next edge.
                    state     <= IDLE;
                    seq_out   <= 1'b0;
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_gen -- self-checking bench for seq_gen.
//
// The reference model describes the expected output stream as a queue of
// per-cycle records built from the transfer rules: each pass contributes its
// bits MSB-first, passes are separated by a gap cycle when SEQ_GAP_EN is
// defined, and every transfer ends with one DONE cycle and one IDLE cycle.
// A new transfer is appended only when the model is idle and start is high.
// ---------------------------------------------------------------------------
module tb_seq_gen;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 4;
    localparam int REP_W   = 4;

`ifdef SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic       out;
        logic       busy;
        logic       done;
        logic [3:0] state;
    } rec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len_m1;
    logic [REP_W-1:0]   repeat_n;
    logic               seq_out;
    logic               seq_valid;
    logic               busy;
    logic               done;
    logic [3:0]         state_out;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    logic last_out;
    logic [15:0] collected;

    seq_gen #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .REP_W   (REP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .len_m1    (len_m1),
        .repeat_n  (repeat_n),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .busy      (busy),
        .done      (done),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic rec_t mk(input logic v, input logic o, input logic b,
                                input logic d, input logic [3:0] s);
        rec_t r;
        r.valid = v;
        r.out   = o;
        r.busy  = b;
        r.done  = d;
        r.state = s;
        return r;
    endfunction

    // Append one whole transfer as seen from the outputs.
    task automatic push_transfer(input logic [MAX_LEN-1:0] p, input int len, input int rep);
        int n;
        n = (len > MAX_LEN - 1) ? MAX_LEN - 1 : len;
        for (int pass = 0; pass <= rep; pass++) begin
            for (int b = n; b >= 0; b--) exp_q.push_back(mk(1'b1, p[b], 1'b1, 1'b0, 4'd1));
            if (GAP_ON && pass != rep) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd2));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd3));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    endtask

    // Advance the model for the current inputs, clock once, compare at negedge.
    task automatic step();
        rec_t e;
        if (!rst) begin
            exp_q.delete();
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        end else if (exp_q.size() == 0) begin
            if (start) push_transfer(pattern, int'(len_m1), int'(repeat_n));
            else exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        end
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("seq_valid", 8'(seq_valid), 8'(e.valid));
        check("seq_out",   8'(seq_out),   8'(e.out));
        check("busy",      8'(busy),      8'(e.busy));
        check("done",      8'(done),      8'(e.done));
        check("state_out", 8'(state_out), 8'(e.state));
        last_out = seq_out;
    endtask

    task automatic run_idle_until_empty();
        start = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        pattern  = '0;
        len_m1   = '0;
        repeat_n = '0;
        @(negedge clk);

        // Reset for two edges.
        step();
        step();
        rst = 1'b1;

        // Single pass: 1101.
        pattern = 16'h000D; len_m1 = 4'd3; repeat_n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        run_idle_until_empty();

        // Repeats: 0110 x3.
        pattern = 16'h0006; len_m1 = 4'd3; repeat_n = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        run_idle_until_empty();

        // Minimum length: a single 1.
        pattern = 16'h0001; len_m1 = 4'd0; repeat_n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        run_idle_until_empty();

        // Maximum length: collect the serial word and compare to the pattern.
        pattern = 16'hA5C3; len_m1 = 4'd15; repeat_n = 4'd0; start = 1'b1;
        collected = '0;
        step();
        collected = {collected[14:0], last_out};
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            collected = {collected[14:0], last_out};
        end
        check("max_len_word", collected[7:0], 8'hC3);
        check("max_len_word_hi", collected[15:8], 8'hA5);
        run_idle_until_empty();

        // Handshake: start held high, pattern changed mid-stream.
        pattern = 16'h0009; len_m1 = 4'd3; repeat_n = 4'd0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 2) pattern = 16'h0006;
            if (i == 9) pattern = 16'h000F;
        end
        run_idle_until_empty();

        // Reset at the third bit of a 16-bit transfer, then a fresh pass.
        pattern = 16'hFFFF; len_m1 = 4'd15; repeat_n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        pattern = 16'h000D; len_m1 = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        run_idle_until_empty();

        // Gap-sized case: 11 twice.
        pattern = 16'h0003; len_m1 = 4'd1; repeat_n = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        run_idle_until_empty();

        // Randomized traffic with mid-stream input noise and rare resets.
        for (int i = 0; i < 1500; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            pattern  = MAX_LEN'($urandom);
            len_m1   = LEN_W'($urandom);
            repeat_n = REP_W'($urandom_range(0, 3));
            rst      = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1;
        run_idle_until_empty();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
